// File: rtl/md_pkg.sv
// md_pkg: shared encodings for the multiply/divide unit
package md_pkg;
  typedef enum logic [1:0] {OP_MULTU = 2'b00, OP_MULT = 2'b01, OP_DIVU = 2'b10, OP_DIV = 2'b11} op_t;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;
  localparam logic [31:0] DIVZ_LO = 32'hFFFFFFFF;
endpackage

// File: rtl/md_signfix.sv
// md_signfix: conditional two's-complement negate, used for abs on input and sign restore on output
module md_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? -a : a;
endmodule

// File: rtl/md_unit.sv
// md_unit: iterative 32-cycle multiply/divide unit with architectural HI/LO registers
module md_unit
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  state_t st, st_nx;
  logic sgn, div_r, sa, sb, ge;
  logic [4:0] cnt;
  logic [31:0] ma, mb, abs_a, abs_b, q_fix, r_fix;
  logic [32:0] rem, dif;
  logic [63:0] acc, acc_nx, p_fix;
  assign sgn = op == OP_MULT || op == OP_DIV;
  md_signfix #(.W(32)) u_abs_a (.a(A), .neg(sgn & A[31]), .y(abs_a));
  md_signfix #(.W(32)) u_abs_b (.a(B), .neg(sgn & B[31]), .y(abs_b));
  md_signfix #(.W(64)) u_fix_p (.a(acc), .neg(sa ^ sb), .y(p_fix));
  md_signfix #(.W(32)) u_fix_q (.a(acc[31:0]), .neg(sa ^ sb), .y(q_fix));
  md_signfix #(.W(32)) u_fix_r (.a(acc[63:32]), .neg(sa), .y(r_fix));
  // Both loops consume operand bits MSB first: divide keeps {remainder, quotient} in acc.
  always_comb begin
    st_nx = st == IDLE ? (start ? CALC : IDLE) : st == CALC ? (cnt == 5'd31 ? FIX : CALC) : IDLE;
    busy = st != IDLE;
    done = st == FIX;
    rem = {acc[63:32], ma[~cnt]};
    dif = rem - {1'b0, mb};
    ge = rem >= {1'b0, mb};
    acc_nx = div_r ? {ge ? dif[31:0] : rem[31:0], acc[30:0], ge}
                   : {acc[62:0], 1'b0} + (mb[~cnt] ? {32'd0, ma} : 64'd0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      div_r <= 1'b0;
      sa <= 1'b0;
      sb <= 1'b0;
      ma <= '0;
      mb <= '0;
      acc <= '0;
      cnt <= '0;
      HI <= '0;
      LO <= '0;
    end else begin
      st <= st_nx;
      if (st == IDLE) begin
        if (hi_we) HI <= wdata;
        if (lo_we) LO <= wdata;
        if (start) begin
          div_r <= op == OP_DIVU || op == OP_DIV;
          sa <= sgn & A[31];
          sb <= sgn & B[31];
          ma <= abs_a;
          mb <= abs_b;
          acc <= '0;
          cnt <= '0;
        end
      end
      if (st == CALC) begin
        acc <= acc_nx;
        cnt <= cnt + 5'd1;
      end
      // A zero divisor leaves the dividend as remainder, so only LO needs overriding.
      if (st == FIX) begin
        HI <= div_r ? r_fix : p_fix[63:32];
        LO <= div_r ? (mb == '0 ? DIVZ_LO : q_fix) : p_fix[31:0];
      end
    end
  end
endmodule
